// File: rtl/rgb2gray_pkg.sv
// Shared definitions for the streaming RGB-to-grayscale converter:
// mode encodings, the 8-bit reference weights and their rescaling helper.
package rgb2gray_pkg;

  typedef enum logic [1:0] {
    MODE_LUMA   = 2'd0,
    MODE_AVG    = 2'd1,
    MODE_GREEN  = 2'd2,
    MODE_CUSTOM = 2'd3
  } mode_e;

  // Channel slots in the packed pixel, lowest slice first.
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  localparam int W_LUMA_R  = 77;
  localparam int W_LUMA_G  = 150;
  localparam int W_LUMA_B  = 29;
  localparam int W_AVG_R   = 85;
  localparam int W_AVG_G   = 86;
  localparam int W_AVG_B   = 85;
  localparam int W_GREEN_R = 0;
  localparam int W_GREEN_G = 256;
  localparam int W_GREEN_B = 0;

  function automatic int scale_weight(input int w8, input int coef_w);
    if (coef_w >= 8) begin
      return w8 << (coef_w - 8);
    end
    return w8 >> (8 - coef_w);
  endfunction

  // Built-in weight for one channel; custom mode is resolved by the caller.
  function automatic int mode_weight(input mode_e mode, input int chan, input int coef_w);
    int w8;
    w8 = 0;
    case (mode)
      MODE_LUMA:  w8 = (chan == CH_R) ? W_LUMA_R  : (chan == CH_G) ? W_LUMA_G  : W_LUMA_B;
      MODE_AVG:   w8 = (chan == CH_R) ? W_AVG_R   : (chan == CH_G) ? W_AVG_G   : W_AVG_B;
      MODE_GREEN: w8 = (chan == CH_R) ? W_GREEN_R : (chan == CH_G) ? W_GREEN_G : W_GREEN_B;
      default:    w8 = 0;
    endcase
    return scale_weight(w8, coef_w);
  endfunction

endpackage

// File: rtl/rgb2gray_stream_if.sv
// Pixel-in / gray-out stream bundle plus the config and counter sideband.
interface rgb2gray_stream_if #(
    parameter int CH_W   = 8,
    parameter int COEF_W = 8,
    parameter int CNT_W  = 32
);
  logic                cfg_ld_i;
  logic [1:0]          mode_i;
  logic [COEF_W-1:0]   coef_r_i;
  logic [COEF_W-1:0]   coef_g_i;
  logic [COEF_W-1:0]   coef_b_i;
  logic                valid_i;
  logic                ready_o;
  logic [3*CH_W-1:0]   RgbColor_i;
  logic                last_i;
  logic                valid_o;
  logic                ready_i;
  logic [CH_W-1:0]     GrayColor_o;
  logic                last_o;
  logic [CNT_W-1:0]    count_o;
  logic                clear_i;

  modport slave (
    input  cfg_ld_i, mode_i, coef_r_i, coef_g_i, coef_b_i,
    input  valid_i, RgbColor_i, last_i, ready_i, clear_i,
    output ready_o, valid_o, GrayColor_o, last_o, count_o
  );

  modport master (
    output cfg_ld_i, mode_i, coef_r_i, coef_g_i, coef_b_i,
    output valid_i, RgbColor_i, last_i, ready_i, clear_i,
    input  ready_o, valid_o, GrayColor_o, last_o, count_o
  );
endinterface

// File: rtl/rgb2gray_mac_stage.sv
// Second pipeline stage: sums the weighted products, rounds half up,
// saturates to the channel width and holds the result under backpressure.
module rgb2gray_mac_stage #(
    parameter int CH_W   = 8,
    parameter int COEF_W = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             s1_valid,
  input  logic [3*(CH_W+COEF_W+1)-1:0]     s1_prod,
  input  logic                             s1_last,
  input  logic                             dn_ready,
  output logic                             adv,
  output logic                             gray_valid,
  output logic [CH_W-1:0]                  gray,
  output logic                             gray_last
);

  localparam int PW = CH_W + COEF_W + 1;
  localparam int SW = PW + 2;
  localparam int RW = SW - COEF_W;
  localparam logic [SW-1:0] RND = SW'(1) << (COEF_W - 1);

  logic [SW-1:0]   sum;
  logic [RW-1:0]   res;
  logic [CH_W-1:0] sat;
  logic            valid_reg;
  logic            last_reg;
  logic [CH_W-1:0] gray_reg;

  always_comb begin
    sum = SW'(s1_prod[0 +: PW]) + SW'(s1_prod[PW +: PW]) + SW'(s1_prod[2*PW +: PW]) + RND;
  end

  assign res = RW'(sum >> COEF_W);
  assign sat = (|res[RW-1:CH_W]) ? {CH_W{1'b1}} : res[CH_W-1:0];

  // The stage may take new data when empty or when its current beat leaves.
  assign adv = ~valid_reg | dn_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      gray_reg  <= '0;
    end else if (adv) begin
      valid_reg <= s1_valid;
      if (s1_valid) begin
        gray_reg <= sat;
        last_reg <= s1_last;
      end
    end
  end

  assign gray_valid = valid_reg;
  assign gray       = gray_reg;
  assign gray_last  = last_reg;

endmodule

// File: rtl/rgb2gray_stream.sv
// Streaming RGB-to-grayscale converter: config registers, product stage,
// the add/round/saturate stage and the output transfer counter.
module rgb2gray_stream
  import rgb2gray_pkg::*;
#(
    parameter int CH_W   = 8,
    parameter int COEF_W = 8,
    parameter int CNT_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rgb2gray_stream_if.slave    s
);

  localparam int WW = COEF_W + 1;
  localparam int PW = CH_W + COEF_W + 1;

  mode_e               mode_reg;
  logic [COEF_W-1:0]   coef_reg [3];
  logic                v1_reg;
  logic                last1_reg;
  logic [3*PW-1:0]     prod_bus;
  logic                adv1;
  logic                adv2;
  logic                take;
  logic                xfer;
  logic [CNT_W-1:0]    count_reg;
  logic                gray_valid;
  logic [CH_W-1:0]     gray;
  logic                gray_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_reg <= MODE_LUMA;
      for (int i = 0; i < 3; i++) begin
        coef_reg[i] <= '0;
      end
    end else if (s.cfg_ld_i) begin
      mode_reg       <= mode_e'(s.mode_i);
      coef_reg[CH_R] <= s.coef_r_i;
      coef_reg[CH_G] <= s.coef_g_i;
      coef_reg[CH_B] <= s.coef_b_i;
    end
  end

  assign adv1 = ~v1_reg | adv2;
  assign take = s.valid_i & adv1;

  // Products are formed at acceptance, so each pixel keeps the weights
  // that were live when it entered even if the config changes later.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [CH_W-1:0] ch;
      logic [WW-1:0]   w;
      logic [PW-1:0]   prod_reg;

      assign ch = s.RgbColor_i[gi*CH_W +: CH_W];

      always_comb begin
        w = WW'(mode_weight(mode_reg, gi, COEF_W));
        if (mode_reg == MODE_CUSTOM) begin
          w = {1'b0, coef_reg[gi]};
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          prod_reg <= '0;
        end else if (take) begin
          prod_reg <= PW'(ch) * PW'(w);
        end
      end

      assign prod_bus[gi*PW +: PW] = prod_reg;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_reg    <= 1'b0;
      last1_reg <= 1'b0;
    end else if (adv1) begin
      v1_reg <= s.valid_i;
      if (s.valid_i) begin
        last1_reg <= s.last_i;
      end
    end
  end

  rgb2gray_mac_stage #(
    .CH_W   (CH_W),
    .COEF_W (COEF_W)
  ) u_mac (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s1_valid   (v1_reg),
    .s1_prod    (prod_bus),
    .s1_last    (last1_reg),
    .dn_ready   (s.ready_i),
    .adv        (adv2),
    .gray_valid (gray_valid),
    .gray       (gray),
    .gray_last  (gray_last)
  );

  assign xfer = gray_valid & s.ready_i;

  // A clear coinciding with a transfer still counts that transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (s.clear_i) begin
      count_reg <= xfer ? CNT_W'(1) : '0;
    end else if (xfer) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign s.ready_o     = adv1;
  assign s.valid_o     = gray_valid;
  assign s.GrayColor_o = gray;
  assign s.last_o      = gray_last;
  assign s.count_o     = count_reg;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Randomised and directed checks of rgb2gray_stream against a plain
// arithmetic grayscale model, including backpressure, config and counter cases.
module tb_rgb2gray_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb2gray_stream_if #(.CH_W(8), .COEF_W(8), .CNT_W(32)) bus ();
  rgb2gray_stream_if #(.CH_W(8), .COEF_W(8), .CNT_W(4))  bus4 ();

  rgb2gray_stream #(.CH_W(8), .COEF_W(8), .CNT_W(32)) dut (
    .clk_i (clk), .rst_i (rst), .s (bus)
  );
  rgb2gray_stream #(.CH_W(8), .COEF_W(8), .CNT_W(4)) dut4 (
    .clk_i (clk), .rst_i (rst), .s (bus4)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Model config state, updated on the edge that loads it.
  int model_mode = 0;
  int model_cr = 0, model_cg = 0, model_cb = 0;

  logic [23:0] in_rgb_q[$];
  bit          in_last_q[$];
  int          exp_gray_q[$];
  bit          exp_last_q[$];
  int          got_gray_q[$];
  bit          got_last_q[$];
  int          cfg_idx = -1;
  int          cfg_mode_new = 0;
  int          cfg_cr_new = 0, cfg_cg_new = 0, cfg_cb_new = 0;
  int          stall_bad = 0;
  int          stall_obs = 0;
  bit          timed_out = 0;

  function automatic int ref_gray(input logic [23:0] rgb, input int mode,
                                  input int cr, input int cg, input int cb);
    int r, g, b, wr, wg, wb, y;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    case (mode)
      0:       begin wr = 77; wg = 150; wb = 29; end
      1:       begin wr = 85; wg = 86;  wb = 85; end
      2:       begin wr = 0;  wg = 256; wb = 0;  end
      default: begin wr = cr; wg = cg;  wb = cb; end
    endcase
    y = (r * wr + g * wg + b * wb + 128) / 256;
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic model_reset();
    model_mode = 0; model_cr = 0; model_cg = 0; model_cb = 0;
  endtask

  task automatic load_cfg(input int mode, input int cr, input int cg, input int cb);
    bus.cfg_ld_i = 1'b1;
    bus.mode_i   = 2'(mode);
    bus.coef_r_i = 8'(cr);
    bus.coef_g_i = 8'(cg);
    bus.coef_b_i = 8'(cb);
    bus.valid_i  = 1'b0;
    @(posedge clk); #1;
    bus.cfg_ld_i = 1'b0;
    model_mode = mode; model_cr = cr; model_cg = cg; model_cb = cb;
  endtask

  // Drives in_rgb_q through the DUT, records what comes out and what the
  // model predicts for each accepted pixel. Comparisons live in the callers.
  task automatic run_stream(input int ready_pct, input int valid_pct, input int max_cycles);
    int  idx = 0;
    int  cyc = 0;
    bit  held = 0;
    bit  cfg_done = 0;
    int  held_gray = 0;
    bit  held_last = 0;
    exp_gray_q.delete(); exp_last_q.delete();
    got_gray_q.delete(); got_last_q.delete();
    stall_bad = 0; stall_obs = 0; timed_out = 0;
    while ((idx < in_rgb_q.size() || got_gray_q.size() < exp_gray_q.size()) && cyc < max_cycles) begin
      if (idx < in_rgb_q.size()) begin
        bus.valid_i    = ($urandom_range(99) < valid_pct);
        bus.RgbColor_i = in_rgb_q[idx];
        bus.last_i     = in_last_q[idx];
      end else begin
        bus.valid_i    = 1'b0;
        bus.RgbColor_i = 24'($urandom);
        bus.last_i     = 1'($urandom);
      end
      bus.cfg_ld_i = (idx == cfg_idx) && !cfg_done;
      bus.mode_i   = 2'(cfg_mode_new);
      bus.coef_r_i = 8'(cfg_cr_new);
      bus.coef_g_i = 8'(cfg_cg_new);
      bus.coef_b_i = 8'(cfg_cb_new);
      bus.ready_i  = ($urandom_range(99) < ready_pct);
      #1;
      if (held && bus.valid_o) begin
        if (int'(bus.GrayColor_o) != held_gray || bus.last_o != held_last) stall_bad++;
      end
      if (bus.valid_o && bus.ready_i) begin
        got_gray_q.push_back(int'(bus.GrayColor_o));
        got_last_q.push_back(bus.last_o);
        held = 0;
      end else if (bus.valid_o) begin
        held = 1; held_gray = int'(bus.GrayColor_o); held_last = bus.last_o;
        stall_obs++;
      end else begin
        held = 0;
      end
      if (bus.valid_i && bus.ready_o) begin
        exp_gray_q.push_back(ref_gray(in_rgb_q[idx], model_mode, model_cr, model_cg, model_cb));
        exp_last_q.push_back(in_last_q[idx]);
        idx++;
      end
      if (bus.cfg_ld_i) begin
        model_mode = cfg_mode_new; model_cr = cfg_cr_new;
        model_cg = cfg_cg_new; model_cb = cfg_cb_new;
        cfg_done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.valid_i  = 1'b0;
    bus.cfg_ld_i = 1'b0;
    bus.ready_i  = 1'b1;
    cfg_idx      = -1;
    timed_out    = (cyc >= max_cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", bus.valid_o); else pass_cnt++;
    chk_cnt++; if (bus.GrayColor_o !== 8'd0) $display("FAIL reset_gray got=%0d want=0", bus.GrayColor_o); else pass_cnt++;
    chk_cnt++; if (bus.last_o !== 1'b0) $display("FAIL reset_last got=%b want=0", bus.last_o); else pass_cnt++;
    chk_cnt++; if (bus.count_o !== 32'd0) $display("FAIL reset_count got=%0d want=0", bus.count_o); else pass_cnt++;
    chk_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.ready_o); else pass_cnt++;
    $display("test_reset: done");
  endtask

  task automatic test_latency();
    bus.ready_i    = 1'b1;
    bus.valid_i    = 1'b1;
    bus.RgbColor_i = {8'd255, 8'd0, 8'd0};
    bus.last_i     = 1'b1;
    #1;
    chk_cnt++; if (bus.ready_o !== 1'b1) $display("FAIL lat_accept ready_o=%b want=1", bus.ready_o); else pass_cnt++;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL lat_early valid_o=%b want=0", bus.valid_o); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL lat_due valid_o=%b want=1", bus.valid_o); else pass_cnt++;
    chk_cnt++; if (bus.GrayColor_o !== 8'd77) $display("FAIL lat_gray got=%0d want=77", bus.GrayColor_o); else pass_cnt++;
    chk_cnt++; if (bus.last_o !== 1'b1) $display("FAIL lat_last got=%b want=1", bus.last_o); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL lat_single valid_o=%b want=0", bus.valid_o); else pass_cnt++;
    $display("test_latency: pixel {255,0,0} gray=77");
  endtask

  task automatic test_mode0();
    int want[3] = '{77, 255, 0};
    in_rgb_q = '{{8'd255, 8'd0, 8'd0}, {8'd255, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd0}};
    in_last_q = '{0, 0, 1};
    run_stream(100, 100, 50);
    chk_cnt++; if (got_gray_q.size() != 3) $display("FAIL mode0_len got=%0d want=3", got_gray_q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < got_gray_q.size(); i++) begin
      chk_cnt++;
      if (got_gray_q[i] !== want[i]) $display("FAIL mode0_px%0d got=%0d want=%0d", i, got_gray_q[i], want[i]);
      else pass_cnt++;
      $display("test_mode0: px%0d gray=%0d", i, got_gray_q[i]);
    end
  endtask

  task automatic test_modes();
    load_cfg(1, 0, 0, 0);
    in_rgb_q = '{{8'd30, 8'd60, 8'd90}}; in_last_q = '{0};
    run_stream(100, 100, 50);
    chk_cnt++; if (got_gray_q.size() != 1 || got_gray_q[0] !== 60) $display("FAIL mode1_avg got=%0d want=60", got_gray_q.size() > 0 ? got_gray_q[0] : -1); else pass_cnt++;
    load_cfg(2, 0, 0, 0);
    in_rgb_q = '{{8'd200, 8'd17, 8'd3}}; in_last_q = '{0};
    run_stream(100, 100, 50);
    chk_cnt++; if (got_gray_q.size() != 1 || got_gray_q[0] !== 17) $display("FAIL mode2_green got=%0d want=17", got_gray_q.size() > 0 ? got_gray_q[0] : -1); else pass_cnt++;
    load_cfg(3, 200, 200, 200);
    in_rgb_q = '{{8'd255, 8'd255, 8'd255}, {8'd1, 8'd1, 8'd1}}; in_last_q = '{0, 1};
    run_stream(100, 100, 50);
    chk_cnt++; if (got_gray_q.size() != 2) $display("FAIL mode3_len got=%0d want=2", got_gray_q.size()); else pass_cnt++;
    if (got_gray_q.size() == 2) begin
      chk_cnt++; if (got_gray_q[0] !== 255) $display("FAIL mode3_sat got=%0d want=255", got_gray_q[0]); else pass_cnt++;
      chk_cnt++; if (got_gray_q[1] !== 2) $display("FAIL mode3_round got=%0d want=2", got_gray_q[1]); else pass_cnt++;
      chk_cnt++; if (got_last_q[1] !== 1'b1) $display("FAIL mode3_last got=%b want=1", got_last_q[1]); else pass_cnt++;
    end
    $display("test_modes: avg/green/custom checked");
  endtask

  task automatic test_cfg_inflight();
    int want;
    load_cfg(0, 0, 0, 0);
    in_rgb_q.delete(); in_last_q.delete();
    for (int i = 0; i < 6; i++) begin
      in_rgb_q.push_back(24'($urandom));
      in_last_q.push_back(i == 5);
    end
    cfg_idx = 2; cfg_mode_new = 1;
    cfg_cr_new = 0; cfg_cg_new = 0; cfg_cb_new = 0;
    run_stream(100, 100, 50);
    chk_cnt++; if (got_gray_q.size() != 6) $display("FAIL cfg_len got=%0d want=6", got_gray_q.size()); else pass_cnt++;
    for (int i = 0; i < 6 && i < got_gray_q.size(); i++) begin
      want = ref_gray(in_rgb_q[i], (i < 3) ? 0 : 1, 0, 0, 0);
      chk_cnt++;
      if (got_gray_q[i] !== want) $display("FAIL cfg_px%0d got=%0d want=%0d", i, got_gray_q[i], want);
      else pass_cnt++;
      $display("test_cfg_inflight: px%0d rgb=%06h gray=%0d", i, in_rgb_q[i], got_gray_q[i]);
    end
  endtask

  task automatic check_stream(input string tag, input int n);
    chk_cnt++; if (timed_out) $display("FAIL %s_timeout got=timeout want=complete", tag); else pass_cnt++;
    chk_cnt++; if (got_gray_q.size() != n) $display("FAIL %s_len got=%0d want=%0d", tag, got_gray_q.size(), n); else pass_cnt++;
    for (int i = 0; i < n && i < got_gray_q.size() && i < exp_gray_q.size(); i++) begin
      chk_cnt++;
      if (got_gray_q[i] !== exp_gray_q[i] || got_last_q[i] !== exp_last_q[i])
        $display("FAIL %s_px%0d got=%0d/%b want=%0d/%b", tag, i, got_gray_q[i], got_last_q[i], exp_gray_q[i], exp_last_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (stall_bad != 0) $display("FAIL %s_stall_hold got=%0d changes want=0", tag, stall_bad); else pass_cnt++;
    $display("%s: %0d pixels, %0d stall cycles observed", tag, got_gray_q.size(), stall_obs);
  endtask

  task automatic test_backpressure();
    load_cfg(0, 0, 0, 0);
    bus.clear_i = 1'b1; bus.ready_i = 1'b0;
    @(posedge clk); #1;
    bus.clear_i = 1'b0;
    in_rgb_q.delete(); in_last_q.delete();
    for (int i = 0; i < 100; i++) begin
      in_rgb_q.push_back(24'($urandom));
      in_last_q.push_back($urandom_range(7) == 0);
    end
    run_stream(30, 80, 5000);
    check_stream("backpressure", 100);
    chk_cnt++; if (bus.count_o !== 32'd100) $display("FAIL bp_count got=%0d want=100", bus.count_o); else pass_cnt++;

    load_cfg(1, 0, 0, 0);
    cfg_idx = 40; cfg_mode_new = 3;
    cfg_cr_new = $urandom_range(255); cfg_cg_new = $urandom_range(255); cfg_cb_new = $urandom_range(255);
    run_stream(30, 80, 5000);
    check_stream("backpressure_cfg", 100);
  endtask

  task automatic test_reset_midstream();
    bit seen = 0;
    load_cfg(2, 0, 0, 0);
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1; bus.RgbColor_i = {8'd10, 8'd200, 8'd30}; bus.last_i = 1'b0;
    @(posedge clk); #1;
    bus.RgbColor_i = {8'd40, 8'd50, 8'd60};
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL midrst_loaded valid_o=%b want=1", bus.valid_o); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    bus.ready_i = 1'b1;
    repeat (4) begin
      if (bus.valid_o) seen = 1;
      @(posedge clk); #1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL midrst_flush got=valid seen want=none"); else pass_cnt++;
    chk_cnt++; if (bus.count_o !== 32'd0) $display("FAIL midrst_count got=%0d want=0", bus.count_o); else pass_cnt++;
    in_rgb_q = '{{8'd255, 8'd0, 8'd0}}; in_last_q = '{0};
    run_stream(100, 100, 50);
    chk_cnt++; if (got_gray_q.size() != 1 || got_gray_q[0] !== 77) $display("FAIL midrst_cfg_luma got=%0d want=77", got_gray_q.size() > 0 ? got_gray_q[0] : -1); else pass_cnt++;
    $display("test_reset_midstream: pipeline flushed, config back to luma");
  endtask

  task automatic test_clear();
    in_rgb_q = '{24'h102030, 24'h405060, 24'h708090}; in_last_q = '{0, 0, 1};
    run_stream(100, 100, 50);
    chk_cnt++; if (bus.count_o !== 32'd4) $display("FAIL clear_pre got=%0d want=4", bus.count_o); else pass_cnt++;
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1; bus.RgbColor_i = 24'hA0B0C0; bus.last_i = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (bus.valid_o !== 1'b1) $display("FAIL clear_held valid_o=%b want=1", bus.valid_o); else pass_cnt++;
    bus.ready_i = 1'b1; bus.clear_i = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (bus.count_o !== 32'd1) $display("FAIL clear_with_xfer got=%0d want=1", bus.count_o); else pass_cnt++;
    bus.ready_i = 1'b0;
    @(posedge clk); #1;
    bus.clear_i = 1'b0; bus.ready_i = 1'b1;
    chk_cnt++; if (bus.count_o !== 32'd0) $display("FAIL clear_alone got=%0d want=0", bus.count_o); else pass_cnt++;
    $display("test_clear: count cleared");
  endtask

  task automatic test_wrap();
    int  xfers = 0;
    bit  take;
    bus4.ready_i = 1'b1;
    for (int c = 0; c < 22; c++) begin
      bus4.valid_i    = (c < 16);
      bus4.RgbColor_i = 24'($urandom);
      #1;
      take = bus4.valid_o && bus4.ready_i;
      @(posedge clk); #1;
      if (take) begin
        xfers++;
        chk_cnt++;
        if (bus4.count_o !== 4'(xfers % 16)) $display("FAIL wrap_count%0d got=%0d want=%0d", xfers, bus4.count_o, xfers % 16);
        else pass_cnt++;
      end
    end
    bus4.valid_i = 1'b0;
    chk_cnt++; if (xfers != 16) $display("FAIL wrap_xfers got=%0d want=16", xfers); else pass_cnt++;
    chk_cnt++; if (bus4.count_o !== 4'd0) $display("FAIL wrap_final got=%0d want=0", bus4.count_o); else pass_cnt++;
    $display("test_wrap: 16 transfers on 4-bit counter, count=%0d", bus4.count_o);
  endtask

  initial begin
    bus.cfg_ld_i = 0; bus.mode_i = 0; bus.coef_r_i = 0; bus.coef_g_i = 0; bus.coef_b_i = 0;
    bus.valid_i = 0; bus.RgbColor_i = 0; bus.last_i = 0; bus.ready_i = 0; bus.clear_i = 0;
    bus4.cfg_ld_i = 0; bus4.mode_i = 0; bus4.coef_r_i = 0; bus4.coef_g_i = 0; bus4.coef_b_i = 0;
    bus4.valid_i = 0; bus4.RgbColor_i = 0; bus4.last_i = 0; bus4.ready_i = 0; bus4.clear_i = 0;
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_mode0();
    test_modes();
    test_cfg_inflight();
    test_backpressure();
    test_reset_midstream();
    test_clear();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
